// File: rtl/egress_read_port_if.sv
// Bus bundle for egress_read_port: the scheduler's routed-byte input, the Avalon-style
// read slave, and the irq/full status lines. The master modport drives it; the slave modport is the port.
interface egress_read_port_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    in_port;
    logic          chipselect;
    logic          read;
    logic [2:0]    address;
    logic [DW-1:0] readdata;
    logic          irq;
    logic [2:0]    full;

    modport master (
        output in_valid, in_data, in_port, chipselect, read, address,
        input  readdata, irq, full
    );

    modport slave (
        input  in_valid, in_data, in_port, chipselect, read, address,
        output readdata, irq, full
    );
endinterface

// File: rtl/egress_read_port.sv
// Egress read port: three per-port byte FIFOs drained over a registered Avalon-style read slave.
// Optional feature: define DROP_COUNT_EN for per-port saturating drop counters at addresses 4..6.
module egress_read_port #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    egress_read_port_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] r_mem [3][DEPTH];
    logic [PW-1:0] r_wptr [3];
    logic [PW-1:0] r_rptr [3];
    logic [CW-1:0] r_count [3];
    logic [2:0]    r_ovf;
    logic [DW-1:0] r_readdata;
    logic          r_irq;
    logic [2:0]    r_full;

    logic          w_rd;
    logic [1:0]    w_idx;
    logic [2:0]    w_nonempty;
    logic [2:0]    w_push;
    logic [2:0]    w_pop;
    logic [2:0]    w_accept;
    logic [2:0]    w_drop;
    logic [CW-1:0] w_count_nxt [3];
    logic [DW-1:0] w_rdata;

`ifdef DROP_COUNT_EN
    logic [7:0]    r_drop_cnt [3];
`endif

    // A push into a full FIFO is still accepted when the same port is popped this cycle.
    always_comb begin
        w_rd  = bus.chipselect && bus.read;
        w_idx = bus.address[1:0] - 2'd1;
        for (int p = 0; p < 3; p++) begin
            w_nonempty[p]  = (r_count[p] != '0);
            w_push[p]      = bus.in_valid && (bus.in_port == 2'(p + 1));
            w_pop[p]       = w_rd && (bus.address == 3'(p + 1)) && w_nonempty[p];
            w_accept[p]    = w_push[p] && ((r_count[p] != CW'(DEPTH)) || w_pop[p]);
            w_drop[p]      = w_push[p] && !w_accept[p];
            w_count_nxt[p] = r_count[p] + CW'(w_accept[p]) - CW'(w_pop[p]);
        end
    end

    // NOTE: every path gets a value because of the default first; without it this block infers a latch.
    always_comb begin
        w_rdata = '0;
        case (bus.address)
            3'd0: begin
                w_rdata[2:0] = w_nonempty;
                w_rdata[6:4] = r_ovf;
            end
            3'd1, 3'd2, 3'd3: begin
                if (w_nonempty[w_idx]) w_rdata = r_mem[w_idx][r_rptr[w_idx]];
            end
`ifdef DROP_COUNT_EN
            3'd4, 3'd5, 3'd6: w_rdata[7:0] = r_drop_cnt[bus.address[1:0]];
`endif
            default: w_rdata = '0;
        endcase
    end

    // NOTE: storage has no reset; the pointers and counts alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (w_accept[p]) r_mem[p][r_wptr[p]] <= bus.in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 3; p++) begin
                r_wptr[p]  <= '0;
                r_rptr[p]  <= '0;
                r_count[p] <= '0;
            end
            r_ovf      <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
            r_full     <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (w_accept[p]) r_wptr[p] <= r_wptr[p] + PW'(1);
                if (w_pop[p])    r_rptr[p] <= r_rptr[p] + PW'(1);
                r_count[p] <= w_count_nxt[p];
                r_full[p]  <= (w_count_nxt[p] == CW'(DEPTH));
            end
            r_irq <= (w_count_nxt[0] != '0) || (w_count_nxt[1] != '0) || (w_count_nxt[2] != '0);
            if (w_rd) r_readdata <= w_rdata;
            // A drop landing on the clearing status read survives it.
            if (w_rd && (bus.address == 3'd0)) r_ovf <= w_drop;
            else                               r_ovf <= r_ovf | w_drop;
        end
    end

`ifdef DROP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 3; p++) r_drop_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (w_rd && (bus.address == 3'(p + 4)))
                    r_drop_cnt[p] <= w_drop[p] ? 8'd1 : 8'd0;
                else if (w_drop[p] && (r_drop_cnt[p] != 8'hFF))
                    r_drop_cnt[p] <= r_drop_cnt[p] + 8'd1;
            end
        end
    end
`endif

    assign bus.readdata = r_readdata;
    assign bus.irq      = r_irq;
    assign bus.full     = r_full;
endmodule

// File: tb/tb_egress_read_port.sv
// Self-checking bench for egress_read_port (DEPTH=4, DW=8): table-driven vectors with a
// readdata scoreboard, plus hand-written reset and drop-counter sequences.
module tb_egress_read_port;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    typedef struct {
        bit         iv;
        logic [7:0] data;
        logic [1:0] port;
        bit         cs;
        bit         rd;
        logic [2:0] addr;
        bit         chk;
        logic [7:0] exp_rd;
        bit         exp_irq;
        logic [2:0] exp_full;
    } vec_t;

    logic [7:0] q_exp [$];

    egress_read_port_if #(.DW(8)) bus ();

    egress_read_port #(.DEPTH(4), .DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit iv, logic [7:0] d, logic [1:0] port, bit cs, bit rd,
                                logic [2:0] addr, bit chk, logic [7:0] er, bit ei, logic [2:0] ef);
        vec_t v;
        v.iv = iv; v.data = d; v.port = port; v.cs = cs; v.rd = rd; v.addr = addr;
        v.chk = chk; v.exp_rd = er; v.exp_irq = ei; v.exp_full = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_port = 2'd0;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.address = 3'd0;
    endtask

    // One clock of stimulus; expected readdata goes into the scoreboard when the read is issued.
    task automatic step(input vec_t v, input string tag);
        logic [7:0] e;
        @(negedge clk);
        bus.in_valid = v.iv; bus.in_data = v.data; bus.in_port = v.port;
        bus.chipselect = v.cs; bus.read = v.rd; bus.address = v.addr;
        if (v.chk) q_exp.push_back(v.exp_rd);
        @(posedge clk);
        #1;
        if (v.chk) begin
            if (q_exp.size() == 0) begin
                check({tag, "_sb_empty"}, 8'h01, 8'h00);
            end else begin
                e = q_exp.pop_front();
                check({tag, "_rd"}, bus.readdata, e);
            end
        end
        check({tag, "_irq"}, {7'b0, bus.irq}, {7'b0, v.exp_irq});
        check({tag, "_full"}, {5'b0, bus.full}, {5'b0, v.exp_full});
    endtask

    function automatic vec_t push(logic [7:0] d, logic [1:0] port, bit ei, logic [2:0] ef);
        return mk(1, d, port, 0, 0, 3'd0, 0, 8'h00, ei, ef);
    endfunction

    function automatic vec_t rdv(logic [2:0] addr, logic [7:0] er, bit ei, logic [2:0] ef);
        return mk(0, 8'h00, 2'd0, 1, 1, addr, 1, er, ei, ef);
    endfunction

    initial begin
        vec_t tbl [$];
        n_checks = 0;
        n_fail   = 0;

        // Reset / status / port 2 basic
        tbl.push_back(rdv(3'd0, 8'h00, 0, 3'b000));
        tbl.push_back(push(8'h11, 2'd2, 1, 3'b000));
        tbl.push_back(push(8'h22, 2'd2, 1, 3'b000));
        tbl.push_back(rdv(3'd2, 8'h11, 1, 3'b000));
        tbl.push_back(rdv(3'd2, 8'h22, 0, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'd0, 1, 0, 3'd2, 1, 8'h22, 0, 3'b000));
        tbl.push_back(rdv(3'd2, 8'h00, 0, 3'b000));
        // Port 1 overflow and sticky status
        tbl.push_back(push(8'hA0, 2'd1, 1, 3'b000));
        tbl.push_back(push(8'hA1, 2'd1, 1, 3'b000));
        tbl.push_back(push(8'hA2, 2'd1, 1, 3'b000));
        tbl.push_back(push(8'hA3, 2'd1, 1, 3'b001));
        tbl.push_back(push(8'hA4, 2'd1, 1, 3'b001));
        tbl.push_back(rdv(3'd0, 8'h11, 1, 3'b001));
        tbl.push_back(rdv(3'd0, 8'h01, 1, 3'b001));
        tbl.push_back(rdv(3'd1, 8'hA0, 1, 3'b000));
        tbl.push_back(rdv(3'd1, 8'hA1, 1, 3'b000));
        tbl.push_back(rdv(3'd1, 8'hA2, 1, 3'b000));
        tbl.push_back(rdv(3'd1, 8'hA3, 0, 3'b000));
        tbl.push_back(rdv(3'd1, 8'h00, 0, 3'b000));
        // Port 3 full with simultaneous push and pop
        tbl.push_back(push(8'h31, 2'd3, 1, 3'b000));
        tbl.push_back(push(8'h32, 2'd3, 1, 3'b000));
        tbl.push_back(push(8'h33, 2'd3, 1, 3'b000));
        tbl.push_back(push(8'h34, 2'd3, 1, 3'b100));
        tbl.push_back(mk(1, 8'h55, 2'd3, 1, 1, 3'd3, 1, 8'h31, 1, 3'b100));
        tbl.push_back(rdv(3'd0, 8'h04, 1, 3'b100));
        tbl.push_back(rdv(3'd3, 8'h32, 1, 3'b000));
        tbl.push_back(rdv(3'd3, 8'h33, 1, 3'b000));
        tbl.push_back(rdv(3'd3, 8'h34, 1, 3'b000));
        tbl.push_back(rdv(3'd3, 8'h55, 0, 3'b000));
        // Port 1 empty with simultaneous push and pop
        tbl.push_back(mk(1, 8'h77, 2'd1, 1, 1, 3'd1, 1, 8'h00, 1, 3'b000));
        tbl.push_back(rdv(3'd1, 8'h77, 0, 3'b000));
        // Port 0 ignored, unqualified strobes, unused addresses
        tbl.push_back(push(8'h99, 2'd0, 0, 3'b000));
        tbl.push_back(rdv(3'd0, 8'h00, 0, 3'b000));
        tbl.push_back(push(8'h88, 2'd1, 1, 3'b000));
        tbl.push_back(rdv(3'd0, 8'h01, 1, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'd0, 0, 1, 3'd1, 1, 8'h01, 1, 3'b000));
        tbl.push_back(rdv(3'd1, 8'h88, 0, 3'b000));
        tbl.push_back(rdv(3'd6, 8'h00, 0, 3'b000));
        tbl.push_back(rdv(3'd2, 8'h00, 0, 3'b000));
        tbl.push_back(rdv(3'd7, 8'h00, 0, 3'b000));
        // Overflow coinciding with a status read: set wins
        tbl.push_back(push(8'h21, 2'd2, 1, 3'b000));
        tbl.push_back(push(8'h22, 2'd2, 1, 3'b000));
        tbl.push_back(push(8'h23, 2'd2, 1, 3'b000));
        tbl.push_back(push(8'h24, 2'd2, 1, 3'b010));
        tbl.push_back(mk(1, 8'h25, 2'd2, 1, 1, 3'd0, 1, 8'h02, 1, 3'b010));
        tbl.push_back(rdv(3'd0, 8'h22, 1, 3'b010));
        tbl.push_back(rdv(3'd0, 8'h02, 1, 3'b010));
        tbl.push_back(rdv(3'd2, 8'h21, 1, 3'b000));
        tbl.push_back(rdv(3'd2, 8'h22, 1, 3'b000));
        tbl.push_back(rdv(3'd2, 8'h23, 1, 3'b000));
        tbl.push_back(rdv(3'd2, 8'h24, 0, 3'b000));

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_readdata", bus.readdata, 8'h00);
        check("rst_irq", {7'b0, bus.irq}, 8'h00);
        check("rst_full", {5'b0, bus.full}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 4; i++)
            step(push(8'h60 + 8'(i), 2'd3, 1, (i == 3) ? 3'b100 : 3'b000), $sformatf("mid_fill%0d", i));
        step(push(8'h66, 2'd1, 1, 3'b100), "mid_push");
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        check("mid_rst_readdata", bus.readdata, 8'h00);
        check("mid_rst_irq", {7'b0, bus.irq}, 8'h00);
        check("mid_rst_full", {5'b0, bus.full}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        step(rdv(3'd1, 8'h00, 0, 3'b000), "mid_after_p1");
        step(rdv(3'd3, 8'h00, 0, 3'b000), "mid_after_p3");

        // Drop counter on port 2
        for (int i = 0; i < 4; i++)
            step(push(8'h40 + 8'(i), 2'd2, 1, (i == 3) ? 3'b010 : 3'b000), $sformatf("dc_fill%0d", i));
`ifdef DROP_COUNT_EN
        for (int i = 0; i < 300; i++) step(push(8'hEE, 2'd2, 1, 3'b010), $sformatf("dc_drop%0d", i));
        step(rdv(3'd5, 8'hFF, 1, 3'b010), "dc_sat");
        step(rdv(3'd5, 8'h00, 1, 3'b010), "dc_cleared");
        step(mk(1, 8'hEE, 2'd2, 1, 1, 3'd5, 1, 8'h00, 1, 3'b010), "dc_drop_on_clear");
        step(rdv(3'd5, 8'h01, 1, 3'b010), "dc_one");
        step(rdv(3'd4, 8'h00, 1, 3'b010), "dc_port1");
        step(rdv(3'd7, 8'h00, 1, 3'b010), "dc_addr7");
`else
        step(push(8'hEE, 2'd2, 1, 3'b010), "dc_drop");
        step(rdv(3'd0, 8'h22, 1, 3'b010), "dc_status");
        step(rdv(3'd5, 8'h00, 1, 3'b010), "dc_addr5");
        step(rdv(3'd4, 8'h00, 1, 3'b010), "dc_addr4");
`endif
        idle();

        check("sb_drained", 8'(q_exp.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
